// File: rtl/ps2_keypad_decoder.sv
// ps2_keypad_decoder: set-2 numeric keypad scan-code decoder with prefix FSM, event FIFO and key state vectors.
// Optional build macro KBD_TYPEMATIC_FILTER_EN: suppress repeated makes of an already held key.
module ps2_keypad_decoder #(
    parameter int NUM_KEYS       = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          Reset_n,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          ev_ready,
    input  logic                          ovf_clr,
    output logic                          ev_valid,
    output logic [3:0]                    ev_key,
    output logic                          ev_break,
    output logic [NUM_KEYS-1:0]           key_down,
    output logic [NUM_KEYS-1:0]           key_toggle,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic [NUM_KEYS-1:0]   down_q, down_d, tog_q, tog_d;
    logic [4:0]            mem_q [FIFO_DEPTH];
    logic [4:0]            mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]         lvl_q, lvl_d;
    logic                  ovf_q, ovf_d;
    logic                  ext, brk, is_e0, is_f0, fin, tmo;
    logic                  hit_raw, hit, held, fire, full, pop, push_ok, drop;
    logic [3:0]            idx;

    // Returns {hit, index} for a code, using the extended table when e is set.
    function automatic logic [4:0] map_code(input logic e, input logic [7:0] c);
        map_code = 5'h00;
        if (e)
            map_code = c == 8'h5A ? 5'h1D : c == 8'h4A ? 5'h1E : 5'h00;
        else
            case (c)
                8'h70: map_code = 5'h10;
                8'h69: map_code = 5'h11;
                8'h72: map_code = 5'h12;
                8'h7A: map_code = 5'h13;
                8'h6B: map_code = 5'h14;
                8'h73: map_code = 5'h15;
                8'h74: map_code = 5'h16;
                8'h6C: map_code = 5'h17;
                8'h75: map_code = 5'h18;
                8'h7D: map_code = 5'h19;
                8'h79: map_code = 5'h1A;
                8'h7B: map_code = 5'h1B;
                8'h7C: map_code = 5'h1C;
                8'h71: map_code = 5'h1F;
                default: map_code = 5'h00;
            endcase
    endfunction

    // Prefix FSM: E0/F0 accumulate, any other byte terminates; idle prefixes time out.
    always_comb begin
        ext     = state_q == GOT_E0 || state_q == GOT_E0F0;
        brk     = state_q == GOT_F0 || state_q == GOT_E0F0;
        is_e0   = rx_data == 8'hE0;
        is_f0   = rx_data == 8'hF0;
        fin     = rx_valid && !is_e0 && !is_f0;
        tmo     = state_q != IDLE && cnt_q == TW'(TIMEOUT_CYCLES - 1);
        cnt_d   = rx_valid || tmo || state_q == IDLE ? '0 : cnt_q + TW'(1);
        state_d = !rx_valid ? (tmo ? IDLE : state_q) :
                  is_e0     ? (state_q == GOT_E0F0 ? GOT_E0F0 : GOT_E0) :
                  is_f0     ? (ext ? GOT_E0F0 : GOT_F0) : IDLE;
    end

    // Key decode and held/toggle vector update; these track every hit even when the FIFO drops it.
    always_comb begin
        {hit_raw, idx} = map_code(ext, rx_data);
        hit  = fin && hit_raw && int'(idx) < NUM_KEYS;
        held = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++)
            if (int'(idx) == i) held = down_q[i];
`ifdef KBD_TYPEMATIC_FILTER_EN
        fire = hit && (brk || !held);
`else
        fire = hit;
`endif
        down_d = down_q;
        tog_d  = tog_q;
        for (int i = 0; i < NUM_KEYS; i++)
            if (fire && int'(idx) == i) begin
                down_d[i] = !brk;
                tog_d[i]  = tog_q[i] ^ brk;
            end
    end

    // Event FIFO: a full FIFO still accepts a push when the head is popped on the same edge.
    always_comb begin
        full    = lvl_q == LW'(FIFO_DEPTH);
        pop     = ev_valid && ev_ready;
        push_ok = fire && (!full || pop);
        drop    = fire && full && !pop;
        mem_d   = mem_q;
        if (push_ok) mem_d[wp_q] = {brk, idx};
        wp_d    = wp_q + AW'(push_ok);
        rp_d    = rp_q + AW'(pop);
        lvl_d   = lvl_q + LW'(push_ok) - LW'(pop);
        ovf_d   = drop || (ovf_q && !ovf_clr);
    end

    // State registers.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            down_q  <= '0;
            tog_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            lvl_q   <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            down_q  <= down_d;
            tog_q   <= tog_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
            mem_q   <= mem_d;
        end
    end

    assign ev_valid              = lvl_q != '0;
    assign {ev_break, ev_key}    = ev_valid ? mem_q[rp_q] : 5'h00;
    assign key_down              = down_q;
    assign key_toggle            = tog_q;
    assign overflow              = ovf_q;
    assign fifo_level            = lvl_q;
endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// tb_ps2_keypad_decoder: directed scenarios for the keypad decoder with hand-computed expectations.
module tb_ps2_keypad_decoder;
    localparam int T = 20;

    logic        clk = 1'b0, Reset_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0, ev_ready = 1'b0, ovf_clr = 1'b0;
    logic        ev_valid, ev_break, overflow;
    logic [3:0]  ev_key;
    logic [15:0] key_down, key_toggle;
    logic [2:0]  fifo_level;
    int          n_chk = 0, n_fail = 0;
    logic [4:0]  evq [$];

    ps2_keypad_decoder #(.NUM_KEYS(16), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .Reset_n(Reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .ev_ready(ev_ready), .ovf_clr(ovf_clr), .ev_valid(ev_valid), .ev_key(ev_key),
        .ev_break(ev_break), .key_down(key_down), .key_toggle(key_toggle),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Log every event the consumer accepts, as {break, key}.
    always @(negedge clk) if (Reset_n && ev_valid && ev_ready) evq.push_back({ev_break, ev_key});

    task automatic send(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(posedge clk); #2;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        #12;
        n_chk++; if ({ev_valid, ev_key, ev_break, overflow, fifo_level} !== 10'h000) begin n_fail++; $display("FAIL reset_ctrl: got %h want 000", {ev_valid, ev_key, ev_break, overflow, fifo_level}); end
        n_chk++; if ({key_down, key_toggle} !== 32'h0) begin n_fail++; $display("FAIL reset_keys: got %h want 0", {key_down, key_toggle}); end
        @(posedge clk); #2;
        Reset_n = 1'b1;
    endtask

    task automatic test_make_break;
        ev_ready = 1'b1;
        send(8'h70);
        n_chk++; if (key_down !== 16'h0001) begin n_fail++; $display("FAIL mb_down1: got %h want 0001", key_down); end
        send(8'hF0); send(8'h70);
        n_chk++; if (key_down !== 16'h0000) begin n_fail++; $display("FAIL mb_down0: got %h want 0000", key_down); end
        n_chk++; if (key_toggle !== 16'h0001) begin n_fail++; $display("FAIL mb_toggle: got %h want 0001", key_toggle); end
        idle(2);
        n_chk++; if (evq.size() != 2 || evq[0] !== 5'h00 || evq[1] !== 5'h10) begin n_fail++; $display("FAIL mb_events: got %p want '{00,10}", evq); end
        evq.delete();
    endtask

    task automatic test_extended;
        send(8'hE0); send(8'h5A);
        n_chk++; if (key_down !== 16'h2000) begin n_fail++; $display("FAIL ext_down: got %h want 2000", key_down); end
        send(8'hE0); send(8'hF0); send(8'h5A);
        n_chk++; if ({key_down, key_toggle} !== 32'h0000_2001) begin n_fail++; $display("FAIL ext_break: got %h want 00002001", {key_down, key_toggle}); end
        send(8'h5A); send(8'hAA);
        idle(2);
        n_chk++; if (evq.size() != 2 || evq[0] !== 5'h0D || evq[1] !== 5'h1D) begin n_fail++; $display("FAIL ext_events: got %p want '{0d,1d}", evq); end
        n_chk++; if (key_down !== 16'h0000) begin n_fail++; $display("FAIL ext_plain5a: got %h want 0000", key_down); end
        evq.delete();
    endtask

    task automatic test_overflow;
        ev_ready = 1'b0;
        send(8'h69); send(8'h72); send(8'h7A); send(8'h6B); send(8'h73); send(8'h74);
        n_chk++; if (fifo_level !== 3'd4 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_level: got lvl %0d ovf %b want 4 1", fifo_level, overflow); end
        n_chk++; if (key_down !== 16'h007E) begin n_fail++; $display("FAIL ovf_down: got %h want 007e", key_down); end
        n_chk++; if ({ev_valid, ev_break, ev_key} !== 6'b1_0_0001) begin n_fail++; $display("FAIL ovf_head: got %b want 100001", {ev_valid, ev_break, ev_key}); end
        ev_ready = 1'b1; idle(5); ev_ready = 1'b0;
        n_chk++; if (evq.size() != 4 || evq[0] !== 5'h01 || evq[1] !== 5'h02 || evq[2] !== 5'h03 || evq[3] !== 5'h04) begin n_fail++; $display("FAIL ovf_drain: got %p want '{01,02,03,04}", evq); end
        n_chk++; if (fifo_level !== 3'd0 || ev_valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after: got lvl %0d v %b ovf %b want 0 0 1", fifo_level, ev_valid, overflow); end
        ovf_clr = 1'b1; idle(1); ovf_clr = 1'b0;
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", overflow); end
        evq.delete();
    endtask

    task automatic test_full_push_pop;
        ev_ready = 1'b0;
        send(8'hF0); send(8'h69); send(8'hF0); send(8'h72);
        send(8'hF0); send(8'h7A); send(8'hF0); send(8'h6B);
        send(8'hF0);
        ev_ready = 1'b1; send(8'h73); ev_ready = 1'b0;
        n_chk++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_level: got lvl %0d ovf %b want 4 0", fifo_level, overflow); end
        ev_ready = 1'b1; idle(5); ev_ready = 1'b0;
        n_chk++; if (evq.size() != 5 || evq[0] !== 5'h11 || evq[3] !== 5'h14 || evq[4] !== 5'h15) begin n_fail++; $display("FAIL fpp_events: got %p want '{11,12,13,14,15}", evq); end
        n_chk++; if ({key_down, key_toggle} !== 32'h0040_203F) begin n_fail++; $display("FAIL fpp_keys: got %h want 0040203f", {key_down, key_toggle}); end
        evq.delete();
    endtask

    task automatic test_timeout;
        ev_ready = 1'b1;
        send(8'hF0); idle(T); send(8'h69);
        n_chk++; if (key_down !== 16'h0042) begin n_fail++; $display("FAIL tmo_down: got %h want 0042", key_down); end
        idle(2);
        n_chk++; if (evq.size() != 1 || evq[0] !== 5'h01) begin n_fail++; $display("FAIL tmo_event: got %p want '{01}", evq); end
        evq.delete();
        send(8'hF0); idle(T - 1); send(8'h69);
        n_chk++; if ({key_down, key_toggle} !== 32'h0040_203D) begin n_fail++; $display("FAIL tmo_edge: got %h want 0040203d", {key_down, key_toggle}); end
        idle(2);
        n_chk++; if (evq.size() != 1 || evq[0] !== 5'h11) begin n_fail++; $display("FAIL tmo_edge_event: got %p want '{11}", evq); end
        evq.delete();
    endtask

    task automatic test_typematic;
        int exp_n;
`ifdef KBD_TYPEMATIC_FILTER_EN
        exp_n = 1;
`else
        exp_n = 3;
`endif
        send(8'h75); send(8'h75); send(8'h75);
        n_chk++; if (key_down !== 16'h0140) begin n_fail++; $display("FAIL typ_down: got %h want 0140", key_down); end
        idle(2);
        n_chk++; if (evq.size() != exp_n || evq[0] !== 5'h08 || evq[exp_n-1] !== 5'h08) begin n_fail++; $display("FAIL typ_events: got %p want %0d x 08", evq, exp_n); end
        send(8'hF0); send(8'h75); idle(2);
        evq.delete();
    endtask

    task automatic test_reset_midseq;
        send(8'hE0);
        #3 Reset_n = 1'b0;
        #1;
        n_chk++; if ({ev_valid, ev_key, ev_break, overflow, fifo_level, key_down, key_toggle} !== 42'h0) begin n_fail++; $display("FAIL rst_async: got %h want 0", {ev_valid, ev_key, ev_break, overflow, fifo_level, key_down, key_toggle}); end
        idle(2);
        Reset_n = 1'b1;
        send(8'hF0); send(8'h4A); idle(2);
        n_chk++; if (evq.size() != 0 || ev_valid !== 1'b0 || {key_down, key_toggle} !== 32'h0) begin n_fail++; $display("FAIL rst_prefix: got n=%0d v=%b keys=%h want 0 0 0", evq.size(), ev_valid, {key_down, key_toggle}); end
    endtask

    initial begin
        test_reset;
        test_make_break;
        test_extended;
        test_overflow;
        test_full_push_pop;
        test_timeout;
        test_typematic;
        test_reset_midseq;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
